// File: rtl/alu_op_sched.sv
// REF-domain sequencer: gates the ALU clock, issues one ALU_EN pulse per request,
// waits for the result with a timeout, then writes it to the TX FIFO LSB first.
module alu_op_sched #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FUN_WIDTH  = 4,
   parameter int unsigned GATE_SETUP = 1,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [FUN_WIDTH-1:0]    req_fun,
   output logic                    req_ready,
   output logic                    alu_clk_en,
   output logic                    alu_en,
   output logic [FUN_WIDTH-1:0]    alu_fun,
   input  logic [2*DATA_WIDTH-1:0] alu_out,
   input  logic                    alu_out_valid,
   input  logic                    fifo_full,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_wr_inc,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned RES_W  = 2 * DATA_WIDTH;
   localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GCNT_W = (GATE_SETUP > 1) ? $clog2(GATE_SETUP) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_SETUP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATE_ON,
      S_ISSUE,
      S_WAIT_RES,
      S_SEND_LO,
      S_SEND_HI
   } state_e;

   state_e                 state_q, state_d;
   logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
   logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
   logic [RES_W-1:0]       res_q, res_d;
   logic [FUN_WIDTH-1:0]   fun_q, fun_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gcnt_q  <= '0;
         wcnt_q  <= '0;
         res_q   <= '0;
         fun_q   <= '0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         wcnt_q  <= wcnt_d;
         res_q   <= res_d;
         fun_q   <= fun_d;
      end
   end

   // Next-state and output decode; every output is forced low while rst is asserted
   always_comb begin
      state_d     = state_q;
      gcnt_d      = gcnt_q;
      wcnt_d      = wcnt_q;
      res_d       = res_q;
      fun_d       = fun_q;
      req_ready   = 1'b0;
      alu_clk_en  = 1'b0;
      alu_en      = 1'b0;
      alu_fun     = fun_q;
      tx_data     = '0;
      tx_wr_inc   = 1'b0;
      busy        = (state_q != S_IDLE);
      timeout_err = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               fun_d   = req_fun;
               gcnt_d  = '0;
               wcnt_d  = '0;
               state_d = S_GATE_ON;
            end
         end
         S_GATE_ON: begin
            alu_clk_en = 1'b1;
            if (gcnt_q == GCNT_LAST) begin
               state_d = S_ISSUE;
            end else begin
               gcnt_d = gcnt_q + GCNT_W'(1);
            end
         end
         S_ISSUE: begin
            alu_clk_en = 1'b1;
            alu_en     = 1'b1;
            state_d    = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            alu_clk_en = 1'b1;
            // A result arriving on the last allowed cycle still beats the timeout
            if (alu_out_valid) begin
               res_d   = alu_out;
               state_d = S_SEND_LO;
            end else if (wcnt_q == WCNT_LAST) begin
               timeout_err = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         S_SEND_LO: begin
            tx_data   = res_q[DATA_WIDTH-1:0];
            tx_wr_inc = !fifo_full;
            if (!fifo_full) begin
               state_d = S_SEND_HI;
            end
         end
         S_SEND_HI: begin
            tx_data   = res_q[RES_W-1:DATA_WIDTH];
            tx_wr_inc = !fifo_full;
            if (!fifo_full) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst) begin
         req_ready   = 1'b0;
         alu_clk_en  = 1'b0;
         alu_en      = 1'b0;
         alu_fun     = '0;
         tx_data     = '0;
         tx_wr_inc   = 1'b0;
         busy        = 1'b0;
         timeout_err = 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_sched.sv
// Directed bench for alu_op_sched: inputs driven just after posedge, outputs checked
// shortly afterwards; strobes and ALU_EN pulses are tallied on the falling edge.
module tb_alu_op_sched;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_fun;
   logic        req_ready;
   logic        alu_clk_en;
   logic        alu_en;
   logic [3:0]  alu_fun;
   logic [15:0] alu_out;
   logic        alu_out_valid;
   logic        fifo_full;
   logic [7:0]  tx_data;
   logic        tx_wr_inc;
   logic        busy;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int en_pulses = 0;
   int s0;
   int e0;

   alu_op_sched #(
      .DATA_WIDTH(8),
      .FUN_WIDTH (4),
      .GATE_SETUP(1),
      .TIMEOUT   (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_fun      (req_fun),
      .req_ready    (req_ready),
      .alu_clk_en   (alu_clk_en),
      .alu_en       (alu_en),
      .alu_fun      (alu_fun),
      .alu_out      (alu_out),
      .alu_out_valid(alu_out_valid),
      .fifo_full    (fifo_full),
      .tx_data      (tx_data),
      .tx_wr_inc    (tx_wr_inc),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_wr_inc === 1'b1) strobes++;
      if (alu_en === 1'b1) en_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_fun       = 4'h0;
      alu_out       = 16'h0;
      alu_out_valid = 1'b0;
      fifo_full     = 1'b0;

      // Power-on reset
      nxt(); #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clken", 32'(alu_clk_en), 32'd0);
      nxt(); rst = 1'b0; #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_fun", 32'(alu_fun), 32'd0);

      // Basic operation and latency: fun 0, result 1234
      s0 = strobes;
      req_valid = 1'b1; req_fun = 4'h0; alu_out = 16'h1234; #1;
      chk("t2_c0_ready", 32'(req_ready), 32'd1);
      nxt(); req_valid = 1'b0; #1;
      chk("t2_c1_clken", 32'(alu_clk_en), 32'd1);
      chk("t2_c1_en", 32'(alu_en), 32'd0);
      chk("t2_c1_busy", 32'(busy), 32'd1);
      chk("t2_c1_ready", 32'(req_ready), 32'd0);
      nxt(); #1;
      chk("t2_c2_en", 32'(alu_en), 32'd1);
      chk("t2_c2_clken", 32'(alu_clk_en), 32'd1);
      nxt(); alu_out_valid = 1'b1; #1;
      chk("t2_c3_en", 32'(alu_en), 32'd0);
      chk("t2_c3_clken", 32'(alu_clk_en), 32'd1);
      chk("t2_c3_wr", 32'(tx_wr_inc), 32'd0);
      nxt(); alu_out_valid = 1'b0; alu_out = 16'h0; #1;
      chk("t2_c4_data", 32'(tx_data), 32'h34);
      chk("t2_c4_wr", 32'(tx_wr_inc), 32'd1);
      chk("t2_c4_clken", 32'(alu_clk_en), 32'd0);
      nxt(); #1;
      chk("t2_c5_data", 32'(tx_data), 32'h12);
      chk("t2_c5_wr", 32'(tx_wr_inc), 32'd1);
      nxt(); #1;
      chk("t2_c6_ready", 32'(req_ready), 32'd1);
      chk("t2_c6_busy", 32'(busy), 32'd0);
      chk("t2_c6_wr", 32'(tx_wr_inc), 32'd0);
      chk("t2_strobes", 32'(strobes - s0), 32'd2);

      // FIFO full for 5 cycles in SEND_LO
      s0 = strobes;
      req_valid = 1'b1; req_fun = 4'h9; alu_out = 16'h1234;
      nxt(); req_valid = 1'b0;
      nxt();
      nxt(); alu_out_valid = 1'b1;
      nxt(); alu_out_valid = 1'b0; fifo_full = 1'b1; #1;
      chk("t3_lo_data", 32'(tx_data), 32'h34);
      chk("t3_lo_wr", 32'(tx_wr_inc), 32'd0);
      chk("t3_fun", 32'(alu_fun), 32'h9);
      for (int i = 0; i < 4; i++) begin
         nxt(); #1;
         chk("t3_hold_data", 32'(tx_data), 32'h34);
         chk("t3_hold_wr", 32'(tx_wr_inc), 32'd0);
      end
      nxt(); fifo_full = 1'b0; #1;
      chk("t3_rel_data", 32'(tx_data), 32'h34);
      chk("t3_rel_wr", 32'(tx_wr_inc), 32'd1);
      nxt(); #1;
      chk("t3_hi_data", 32'(tx_data), 32'h12);
      chk("t3_hi_wr", 32'(tx_wr_inc), 32'd1);
      nxt(); #1;
      chk("t3_idle_ready", 32'(req_ready), 32'd1);
      chk("t3_strobes", 32'(strobes - s0), 32'd2);

      // Reset for 2 cycles while in SEND_HI
      s0 = strobes;
      req_valid = 1'b1; req_fun = 4'h5; alu_out = 16'hABCD;
      nxt(); req_valid = 1'b0;
      nxt();
      nxt(); alu_out_valid = 1'b1;
      nxt(); alu_out_valid = 1'b0; #1;
      chk("t1_lo_data", 32'(tx_data), 32'hCD);
      chk("t1_fun", 32'(alu_fun), 32'h5);
      nxt(); rst = 1'b1; #1;
      chk("t1_rst1_wr", 32'(tx_wr_inc), 32'd0);
      chk("t1_rst1_data", 32'(tx_data), 32'd0);
      chk("t1_rst1_busy", 32'(busy), 32'd0);
      chk("t1_rst1_ready", 32'(req_ready), 32'd0);
      chk("t1_rst1_fun", 32'(alu_fun), 32'd0);
      nxt(); #1;
      chk("t1_rst2_wr", 32'(tx_wr_inc), 32'd0);
      chk("t1_rst2_ready", 32'(req_ready), 32'd0);
      nxt(); rst = 1'b0; #1;
      chk("t1_rel_ready", 32'(req_ready), 32'd1);
      chk("t1_rel_busy", 32'(busy), 32'd0);
      chk("t1_rel_fun", 32'(alu_fun), 32'd0);
      chk("t1_strobes", 32'(strobes - s0), 32'd1);

      // Timeout: no result ever arrives
      s0 = strobes;
      req_valid = 1'b1; req_fun = 4'h3;
      nxt(); req_valid = 1'b0;
      nxt();
      for (int i = 0; i < 15; i++) begin
         nxt(); #1;
         chk("t4_wait_to", 32'(timeout_err), 32'd0);
         chk("t4_wait_clken", 32'(alu_clk_en), 32'd1);
      end
      nxt(); #1;
      chk("t4_to_pulse", 32'(timeout_err), 32'd1);
      nxt(); #1;
      chk("t4_after_to", 32'(timeout_err), 32'd0);
      chk("t4_after_clken", 32'(alu_clk_en), 32'd0);
      chk("t4_after_ready", 32'(req_ready), 32'd1);
      chk("t4_strobes", 32'(strobes - s0), 32'd0);

      // Stray valid in IDLE/GATE_ON ignored; valid on last wait cycle beats timeout
      s0 = strobes;
      alu_out = 16'hBEEF; alu_out_valid = 1'b1; #1;
      chk("t6_idle_busy", 32'(busy), 32'd0);
      chk("t6_idle_wr", 32'(tx_wr_inc), 32'd0);
      nxt(); alu_out_valid = 1'b0; req_valid = 1'b1; req_fun = 4'h6;
      nxt(); req_valid = 1'b0; alu_out_valid = 1'b1; #1;
      chk("t6_gate_clken", 32'(alu_clk_en), 32'd1);
      chk("t6_gate_wr", 32'(tx_wr_inc), 32'd0);
      nxt(); alu_out_valid = 1'b0; #1;
      chk("t6_issue_en", 32'(alu_en), 32'd1);
      for (int i = 0; i < 15; i++) begin
         nxt(); #1;
         chk("t6_wait_to", 32'(timeout_err), 32'd0);
      end
      nxt(); alu_out = 16'hA55A; alu_out_valid = 1'b1; #1;
      chk("t6_last_to", 32'(timeout_err), 32'd0);
      nxt(); alu_out_valid = 1'b0; #1;
      chk("t6_lo_data", 32'(tx_data), 32'h5A);
      chk("t6_lo_wr", 32'(tx_wr_inc), 32'd1);
      nxt(); #1;
      chk("t6_hi_data", 32'(tx_data), 32'hA5);
      nxt(); #1;
      chk("t6_idle_ready", 32'(req_ready), 32'd1);
      chk("t6_strobes", 32'(strobes - s0), 32'd2);

      // Back-to-back requests with req_valid held high
      s0 = strobes;
      e0 = en_pulses;
      req_valid = 1'b1; req_fun = 4'h7; alu_out = 16'h0102; alu_out_valid = 1'b1; #1;
      for (int i = 0; i < 18; i++) begin
         chk("t5_ready", 32'(req_ready), 32'((i % 6) == 0));
         chk("t5_en", 32'(alu_en), 32'((i % 6) == 2));
         chk("t5_wr", 32'(tx_wr_inc), 32'(((i % 6) == 4) || ((i % 6) == 5)));
         nxt(); #1;
      end
      req_valid = 1'b0; alu_out_valid = 1'b0; #1;
      chk("t5_end_ready", 32'(req_ready), 32'd1);
      nxt(); #1;
      chk("t5_end_busy", 32'(busy), 32'd0);
      chk("t5_en_pulses", 32'(en_pulses - e0), 32'd3);
      chk("t5_strobes", 32'(strobes - s0), 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
